id_ex_pipe: RTL and testbench
=============================

# id_ex_pipe

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. It sits directly downstream of the `control` decoder and the register file. It registers the decoded control word, operands and register indices into the EX stage. When a load-use dependency exists, it inserts a one-cycle bubble and tells the PC and IF/ID register to hold. It also inserts a bubble on a branch flush and keeps a saturating count of stall cycles for performance debug.

## Interface
- `DW`, 32, datapath width (PC+4, operands, immediate)
- `CW`, 16, stall-counter width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  synchronous active-low reset, sampled on `clk` rising edge
- `id_valid`  in  1  ID stage holds a real instruction (0 = bubble from IF/ID)
- `RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite`  in  1 each  control outputs from `control`
- `ALUop`  in  2  from `control`
- `id_pc4`  in  DW  PC+4 of ID instruction
- `id_rs_data, id_rt_data`  in  DW  register-file read data
- `id_imm`  in  DW  sign-extended immediate
- `id_rs, id_rt, id_rd`  in  5 each  register indices
- `flush`  in  1  branch taken (from EX/MEM); squash ID instruction
- `ex_valid`  out  1  EX stage holds a real instruction
- `ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUsrc, ex_RegWrite`  out  1 each  registered control
- `ex_ALUop`  out  2  registered
- `ex_pc4, ex_rs_data, ex_rt_data, ex_imm`  out  DW  registered
- `ex_rs, ex_rt, ex_rd`  out  5 each  registered
- `stall`  out  1  combinational; 1 = PC and IF/ID must hold this cycle
- `stall_cnt`  out  CW  saturating count of cycles with `stall`=1

## Operation
- Hazard: `haz = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt))`.
- `stall = haz & ~flush`. Flush has priority over stall.
- Bubble condition: `bubble = flush | haz | ~id_valid`.
- On each edge with `rst_n`=1:
  - If `bubble`: `ex_valid` and all nine control outputs are loaded with 0. The data and index fields load the ID inputs unchanged; they are don't-care downstream but stay deterministic.
  - Otherwise: every `ex_*` output loads its ID counterpart and `ex_valid` loads 1.
- Counter: `stall_cnt` increments by 1 on every edge where `stall`=1. It saturates at 2^CW−1 with no wrap.
- The block has no other state. Operationally it behaves as a 2-state machine:
  - RUN → BUBBLE on `haz|flush`.
  - BUBBLE → RUN on the next edge, because the bubble clears `ex_MemRead` and therefore `haz`.

## Timing
- Reset (`rst_n`=0 at an edge): all `ex_*` outputs = 0, `ex_valid` = 0, `stall_cnt` = 0. `stall` = 0 from that edge onward, since it derives from `ex_valid`=0.
- Reset mid-operation: the bubble or stall is discarded and the count clears. Reset overrides `flush` and `haz`.
- Latency: ID inputs appear on `ex_*` one cycle after being sampled.
- Load-use sequence:
  - Cycle N: `lw` is in ID.
  - N+1: `lw` is in EX; the dependent instruction is in ID, so `stall`=1 and upstream holds.
  - End of N+1: bubble loaded.
  - N+2: `stall`=0; the dependent instruction is still in ID because it was held.
  - End of N+2: the dependent instruction is loaded into EX.
  - Exactly one stall cycle per load-use hazard.
- A dependency on `$0` never stalls. A non-load in EX never stalls. A bubble in EX (`ex_valid`=0) never causes a stall.
- Simultaneous `flush` and `haz`: bubble inserted, `stall`=0, counter unchanged.
- Back-to-back `lw` whose dependent is also a load: stall once per pair. There is no chained stall, because the bubble sits between them.

## Test plan
- Reset: drive random inputs, then hold `rst_n`=0 for 2 edges → all outputs 0, `stall`=0, `stall_cnt`=0. Release → outputs follow inputs with 1-cycle latency.
- R-format passthrough: opcode 000000 decode, `id_rs`=8, `id_rt`=9, `id_rd`=10, `id_rs_data`=0x1234 → next cycle `ex_RegDst`=1, `ex_ALUop`=10, `ex_rd`=10, `ex_rs_data`=0x1234, `ex_valid`=1.
- Load-use: `lw $9` (`MemRead`=1, `id_rt`=9) followed by `add` with `id_rs`=9 → `stall`=1 for exactly 1 cycle, then `ex_valid`=0 with all control 0. Next cycle the `add` is in EX; `stall_cnt`=1.
- `$0` and non-load: `lw` with `id_rt`=0 followed by a user with `id_rs`=0 → `stall`=0. `sw` with `id_rt`=9 followed by a user of 9 → `stall`=0.
- Flush vs stall: create the load-use condition and assert `flush` in the same cycle → `stall`=0, bubble loaded, `stall_cnt` unchanged.
- Counter saturation: with `CW`=2, force 5 consecutive stall cycles by repeating the hazard pattern → `stall_cnt` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_pipe_if.sv
// ID/EX pipeline register bus: decoded ID-stage fields in, registered EX-stage fields out.
// The master drives the ID side and flush, and the slave (the pipeline register) drives the EX side.
interface id_ex_pipe_if #(
    parameter int DW = 32,
    parameter int CW = 16
);
    logic          id_valid;
    logic          RegDst;
    logic          Branch;
    logic          MemRead;
    logic          MemtoReg;
    logic          MemWrite;
    logic          ALUsrc;
    logic          RegWrite;
    logic [1:0]    ALUop;
    logic [DW-1:0] id_pc4;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic [4:0]    id_rd;
    logic          flush;

    logic          ex_valid;
    logic          ex_RegDst;
    logic          ex_Branch;
    logic          ex_MemRead;
    logic          ex_MemtoReg;
    logic          ex_MemWrite;
    logic          ex_ALUsrc;
    logic          ex_RegWrite;
    logic [1:0]    ex_ALUop;
    logic [DW-1:0] ex_pc4;
    logic [DW-1:0] ex_rs_data;
    logic [DW-1:0] ex_rt_data;
    logic [DW-1:0] ex_imm;
    logic [4:0]    ex_rs;
    logic [4:0]    ex_rt;
    logic [4:0]    ex_rd;
    logic          stall;
    logic [CW-1:0] stall_cnt;

    modport master (
        output id_valid, RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite,
               ALUop, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, flush,
        input  ex_valid, ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite,
               ex_ALUsrc, ex_RegWrite, ex_ALUop, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, stall, stall_cnt
    );

    modport slave (
        input  id_valid, RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite,
               ALUop, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, flush,
        output ex_valid, ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite,
               ex_ALUsrc, ex_RegWrite, ex_ALUop, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, stall, stall_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazard/flush/empty ID, and a saturating stall-cycle counter.
module id_ex_pipe #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_pipe_if.slave  bus
);
    // Control word packing: {RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite, ALUop[1:0]}
    localparam int CTRL_W   = 9;
    localparam int MEMRD_IX = 6;

    logic              valid_q,   valid_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [DW-1:0]     pc4_q,     pc4_d;
    logic [DW-1:0]     rs_data_q, rs_data_d;
    logic [DW-1:0]     rt_data_q, rt_data_d;
    logic [DW-1:0]     imm_q,     imm_d;
    logic [4:0]        rs_q,      rs_d;
    logic [4:0]        rt_q,      rt_d;
    logic [4:0]        rd_q,      rd_d;
    logic [CW-1:0]     cnt_q,     cnt_d;

    logic [CTRL_W-1:0] id_ctrl;
    logic              haz;
    logic              stall;
    logic              bubble;

    assign id_ctrl = {bus.RegDst, bus.Branch, bus.MemRead, bus.MemtoReg, bus.MemWrite,
                      bus.ALUsrc, bus.RegWrite, bus.ALUop};

    // A bubble in EX clears MemRead, so a hazard can never persist past one cycle.
    assign haz = valid_q & ctrl_q[MEMRD_IX] & (rt_q != 5'd0) & bus.id_valid &
                 ((rt_q == bus.id_rs) | (rt_q == bus.id_rt));
    assign stall  = haz & ~bus.flush;
    assign bubble = bus.flush | haz | ~bus.id_valid;

    always_comb begin
        valid_d   = 1'b1;
        ctrl_d    = id_ctrl;
        pc4_d     = bus.id_pc4;
        rs_data_d = bus.id_rs_data;
        rt_data_d = bus.id_rt_data;
        imm_d     = bus.id_imm;
        rs_d      = bus.id_rs;
        rt_d      = bus.id_rt;
        rd_d      = bus.id_rd;
        cnt_d     = cnt_q;
        if (bubble) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
        if (stall && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc4_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc4_q     <= pc4_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.ex_valid    = valid_q;
    assign bus.ex_RegDst   = ctrl_q[8];
    assign bus.ex_Branch   = ctrl_q[7];
    assign bus.ex_MemRead  = ctrl_q[6];
    assign bus.ex_MemtoReg = ctrl_q[5];
    assign bus.ex_MemWrite = ctrl_q[4];
    assign bus.ex_ALUsrc   = ctrl_q[3];
    assign bus.ex_RegWrite = ctrl_q[2];
    assign bus.ex_ALUop    = ctrl_q[1:0];
    assign bus.ex_pc4      = pc4_q;
    assign bus.ex_rs_data  = rs_data_q;
    assign bus.ex_rt_data  = rt_data_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_rs       = rs_q;
    assign bus.ex_rt       = rt_q;
    assign bus.ex_rd       = rd_q;
    assign bus.stall       = stall;
    assign bus.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: a 16-bit-counter instance plus a 2-bit-counter
// instance that shares the same stimulus, used to check counter saturation.
module tb_id_ex_pipe;
    localparam logic [8:0] C_R  = 9'b100000110;
    localparam logic [8:0] C_LW = 9'b001101100;
    localparam logic [8:0] C_SW = 9'b000011000;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    id_ex_pipe_if #(.DW(32), .CW(16)) ifa ();
    id_ex_pipe_if #(.DW(32), .CW(2))  ifb ();

    id_ex_pipe #(.DW(32), .CW(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    id_ex_pipe #(.DW(32), .CW(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    assign ifb.id_valid   = ifa.id_valid;
    assign ifb.RegDst     = ifa.RegDst;
    assign ifb.Branch     = ifa.Branch;
    assign ifb.MemRead    = ifa.MemRead;
    assign ifb.MemtoReg   = ifa.MemtoReg;
    assign ifb.MemWrite   = ifa.MemWrite;
    assign ifb.ALUsrc     = ifa.ALUsrc;
    assign ifb.RegWrite   = ifa.RegWrite;
    assign ifb.ALUop      = ifa.ALUop;
    assign ifb.id_pc4     = ifa.id_pc4;
    assign ifb.id_rs_data = ifa.id_rs_data;
    assign ifb.id_rt_data = ifa.id_rt_data;
    assign ifb.id_imm     = ifa.id_imm;
    assign ifb.id_rs      = ifa.id_rs;
    assign ifb.id_rt      = ifa.id_rt;
    assign ifb.id_rd      = ifa.id_rd;
    assign ifb.flush      = ifa.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ex_ctrl();
        return {ifa.ex_RegDst, ifa.ex_Branch, ifa.ex_MemRead, ifa.ex_MemtoReg, ifa.ex_MemWrite,
                ifa.ex_ALUsrc, ifa.ex_RegWrite, ifa.ex_ALUop};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) begin
            $display("[TB] check %s obs=%0h ok", tag, obs);
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [8:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] d);
        ifa.id_valid   = v;
        {ifa.RegDst, ifa.Branch, ifa.MemRead, ifa.MemtoReg, ifa.MemWrite,
         ifa.ALUsrc, ifa.RegWrite, ifa.ALUop} = c;
        ifa.id_rs      = rs;
        ifa.id_rt      = rt;
        ifa.id_rd      = rd;
        ifa.id_rs_data = d;
        ifa.id_rt_data = d + 32'h1;
        ifa.id_imm     = d + 32'h2;
        ifa.id_pc4     = d + 32'h4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        tests  = 0;
        failed = 0;

        // Reset with random inputs applied
        rst_n     = 1'b0;
        ifa.flush = 1'b0;
        drive(1'b1, 9'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
        #1;
        tick();
        tick();
        chk("rst_valid", 64'(ifa.ex_valid), 64'd0);
        chk("rst_ctrl", 64'(ex_ctrl()), 64'd0);
        chk("rst_pc4", 64'(ifa.ex_pc4), 64'd0);
        chk("rst_rsdata", 64'(ifa.ex_rs_data), 64'd0);
        chk("rst_rd", 64'(ifa.ex_rd), 64'd0);
        chk("rst_stall", 64'(ifa.stall), 64'd0);
        chk("rst_cnt", 64'(ifa.stall_cnt), 64'd0);

        // R-format passthrough
        rst_n = 1'b1;
        drive(1'b1, C_R, 5'd8, 5'd9, 5'd10, 32'h1234);
        tick();
        chk("r_valid", 64'(ifa.ex_valid), 64'd1);
        chk("r_ctrl", 64'(ex_ctrl()), 64'(C_R));
        chk("r_aluop", 64'(ifa.ex_ALUop), 64'd2);
        chk("r_rd", 64'(ifa.ex_rd), 64'd10);
        chk("r_rsdata", 64'(ifa.ex_rs_data), 64'h1234);
        chk("r_rtdata", 64'(ifa.ex_rt_data), 64'h1235);
        chk("r_pc4", 64'(ifa.ex_pc4), 64'h1238);

        // Load-use: lw $9 then add using $9
        drive(1'b1, C_LW, 5'd4, 5'd9, 5'd0, 32'h40);
        #1;
        chk("lu_nostall_pre", 64'(ifa.stall), 64'd0);
        tick();
        drive(1'b1, C_R, 5'd9, 5'd10, 5'd11, 32'h77);
        #1;
        chk("lu_stall", 64'(ifa.stall), 64'd1);
        tick();
        chk("lu_bub_valid", 64'(ifa.ex_valid), 64'd0);
        chk("lu_bub_ctrl", 64'(ex_ctrl()), 64'd0);
        chk("lu_bub_rs", 64'(ifa.ex_rs), 64'd9);
        chk("lu_cnt", 64'(ifa.stall_cnt), 64'd1);
        chk("lu_stall_gone", 64'(ifa.stall), 64'd0);
        tick();
        chk("lu_add_valid", 64'(ifa.ex_valid), 64'd1);
        chk("lu_add_ctrl", 64'(ex_ctrl()), 64'(C_R));
        chk("lu_add_rd", 64'(ifa.ex_rd), 64'd11);
        chk("lu_cnt_hold", 64'(ifa.stall_cnt), 64'd1);

        // Dependency on $0 never stalls
        drive(1'b1, C_LW, 5'd1, 5'd0, 5'd0, 32'h50);
        tick();
        drive(1'b1, C_R, 5'd0, 5'd5, 5'd6, 32'h51);
        #1;
        chk("zero_stall", 64'(ifa.stall), 64'd0);
        tick();
        chk("zero_valid", 64'(ifa.ex_valid), 64'd1);

        // Store in EX never stalls
        drive(1'b1, C_SW, 5'd2, 5'd9, 5'd0, 32'h60);
        tick();
        drive(1'b1, C_R, 5'd9, 5'd3, 5'd12, 32'h61);
        #1;
        chk("sw_stall", 64'(ifa.stall), 64'd0);
        tick();
        chk("sw_valid", 64'(ifa.ex_valid), 64'd1);
        chk("sw_cnt", 64'(ifa.stall_cnt), 64'd1);

        // Flush together with hazard: bubble, no stall, counter unchanged
        drive(1'b1, C_LW, 5'd1, 5'd7, 5'd0, 32'h70);
        tick();
        drive(1'b1, C_R, 5'd7, 5'd2, 5'd13, 32'h71);
        ifa.flush = 1'b1;
        #1;
        chk("fl_stall", 64'(ifa.stall), 64'd0);
        tick();
        ifa.flush = 1'b0;
        chk("fl_valid", 64'(ifa.ex_valid), 64'd0);
        chk("fl_ctrl", 64'(ex_ctrl()), 64'd0);
        chk("fl_cnt", 64'(ifa.stall_cnt), 64'd1);

        // Empty ID slot becomes a bubble; a bubble in EX never stalls
        drive(1'b0, C_LW, 5'd1, 5'd8, 5'd0, 32'h80);
        tick();
        chk("idv_valid", 64'(ifa.ex_valid), 64'd0);
        chk("idv_ctrl", 64'(ex_ctrl()), 64'd0);
        drive(1'b1, C_R, 5'd8, 5'd8, 5'd14, 32'h81);
        #1;
        chk("idv_nostall", 64'(ifa.stall), 64'd0);
        tick();

        // Reset mid-hazard discards the bubble and clears the count
        drive(1'b1, C_LW, 5'd1, 5'd3, 5'd0, 32'h90);
        tick();
        drive(1'b1, C_R, 5'd3, 5'd4, 5'd15, 32'h91);
        #1;
        chk("mr_stall_pre", 64'(ifa.stall), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_valid", 64'(ifa.ex_valid), 64'd0);
        chk("mr_cnt", 64'(ifa.stall_cnt), 64'd0);
        chk("mr_stall", 64'(ifa.stall), 64'd0);
        chk("mr_cnt_b", 64'(ifb.stall_cnt), 64'd0);
        rst_n = 1'b1;

        // Repeated load-use pairs: 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, C_LW, 5'd1, 5'd9, 5'd0, 32'hA0 + 32'(i));
            tick();
            drive(1'b1, C_R, 5'd9, 5'd2, 5'd16, 32'hB0 + 32'(i));
            #1;
            chk($sformatf("sat_stall%0d", i), 64'(ifb.stall), 64'd1);
            tick();
            chk($sformatf("sat_cnt_b%0d", i), 64'(ifb.stall_cnt), 64'(sat_exp[i]));
            chk($sformatf("sat_cnt_a%0d", i), 64'(ifa.stall_cnt), 64'(i + 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
